// File: rtl/ysyx_25020047_ifu.sv
// ysyx_25020047_ifu -- instruction fetch unit
//
// Accepts a fetch address from the PC unit, issues a single level-held read
// to instruction memory, and presents the returned word to decode with a
// valid/ready handshake. Bus errors, fetch timeouts and (optionally)
// misaligned addresses park the unit in a sticky error state until reset.
//
// Optional feature macro: YSYX_25020047_IFU_ALIGN_CHK_EN
//   defined   -> pc[1:0] != 2'b00 is rejected in IDLE with cause 2'b10
//   undefined -> pc is forwarded unaltered, cause 2'b10 never produced
//
// Parameters:
//   TIMEOUT            max WAIT cycles without a response before timeout
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset
//   pc_i/pc_valid_i    fetch address from PC unit
//   pc_ready_o         IFU accepts pc this cycle (IDLE only)
//   imem_req_o         read request, high for the whole WAIT state
//   imem_addr_o        read address, stable during WAIT
//   imem_rvalid_i      read data valid
//   imem_rdata_i       read data
//   imem_err_i         bus error response
//   inst_o/inst_pc_o   fetched instruction and its address
//   inst_valid_o       inst/inst_pc valid (VALID only)
//   inst_ready_i       decode consumes inst this cycle
//   fetch_err_o        sticky fault flag
//   fetch_err_cause_o  01 bus error, 10 misaligned, 11 timeout, 00 none
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | ready for a new pc
// WAIT  | request outstanding, counting cycles to timeout
// VALID | instruction held for decode until inst_ready
// ERR   | terminal fault, left only by reset

module ysyx_25020047_ifu #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic        fetch_err_o,
    output logic [1:0]  fetch_err_cause_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_BUS     = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
`ifdef YSYX_25020047_IFU_ALIGN_CHK_EN
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
`endif

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [1:0]  cause_q, cause_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            cause_q   <= CAUSE_NONE;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (pc_valid_i) begin
                    inst_pc_d = pc_i;
                    cnt_d     = 16'd0;
`ifdef YSYX_25020047_IFU_ALIGN_CHK_EN
                    if (pc_i[1:0] != 2'b00) begin
                        state_d = ERR;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        addr_d  = pc_i;
                        state_d = WAIT;
                    end
`else
                    addr_d  = pc_i;
                    state_d = WAIT;
`endif
                end
            end
            WAIT: begin
                // Error beats data; data beats the timeout in the same cycle.
                if (imem_err_i) begin
                    state_d = ERR;
                    cause_d = CAUSE_BUS;
                end else if (imem_rvalid_i) begin
                    inst_d  = imem_rdata_i;
                    state_d = VALID;
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    state_d = ERR;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            VALID: begin
                if (inst_ready_i) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc_ready_o        = (state_q == IDLE);
    assign imem_req_o        = (state_q == WAIT);
    assign imem_addr_o       = addr_q;
    assign inst_o            = inst_q;
    assign inst_pc_o         = inst_pc_q;
    assign inst_valid_o      = (state_q == VALID);
    assign fetch_err_o       = (state_q == ERR);
    assign fetch_err_cause_o = cause_q;

endmodule
